// File: rtl/fwd_pkg.sv
// Shared constants and types for the operand forwarding / hazard unit.
//   REG_AW, NREGS  : architectural register index width and count
//   REG_ZERO       : hard-wired zero register index
//   hazard_cause_e : reason the ID instruction is held (debug / assertions)
package fwd_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    HZ_NONE       = 2'd0,
    HZ_NOT_READY  = 2'd1,
    HZ_SCOREBOARD = 2'd2,
    HZ_WAW        = 2'd3
  } hazard_cause_e;

endpackage

// File: rtl/forward_operand_sel.sv
// Single-operand bypass selector.
// Searches the in-flight stages youngest first, then the long-op completion
// port, then falls back to the register file.
//   rs                 : source register index
//   fw_valid/rd/ready/data : packed per-stage forwarding sources
//   lop_done/_rd/_data : long-latency completion port
//   rf_data            : register-file read value
//   data               : selected operand value
//   not_ready          : first matching stage has no result yet
//   lop_hit            : completion port writes rs this cycle
module forward_operand_sel
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NSTAGE = 2
) (
  input  logic [REG_AW-1:0]        rs,
  input  logic [NSTAGE-1:0]        fw_valid,
  input  logic [REG_AW*NSTAGE-1:0] fw_rd,
  input  logic [NSTAGE-1:0]        fw_ready,
  input  logic [XLEN*NSTAGE-1:0]   fw_data,
  input  logic                     lop_done,
  input  logic [REG_AW-1:0]        lop_done_rd,
  input  logic [XLEN-1:0]          lop_done_data,
  input  logic [XLEN-1:0]          rf_data,
  output logic [XLEN-1:0]          data,
  output logic                     not_ready,
  output logic                     lop_hit
);

  logic stage_hit;

  // Lowest-index matching stage wins; a not-ready youngest match masks
  // every older stage so stale data can never leak through.
  always_comb begin
    stage_hit = 1'b0;
    not_ready = 1'b0;
    lop_hit   = lop_done && (lop_done_rd == rs) && (rs != REG_ZERO);
    data      = lop_hit ? lop_done_data : rf_data;
    for (int i = 0; i < int'(NSTAGE); i++) begin
      if (!stage_hit && fw_valid[i] && (rs != REG_ZERO) &&
          (fw_rd[i*REG_AW +: REG_AW] == rs)) begin
        stage_hit = 1'b1;
        not_ready = !fw_ready[i];
        data      = fw_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand bypass, hazard detection and long-op scoreboard for the ID stage.
//   id_*          : instruction in ID (sources, destination, long-op flag)
//   fw_*          : NSTAGE packed forwarding stages, index 0 youngest
//   lop_done*     : long-latency op completion port
//   ext_hold      : downstream hold, blocks issue but is not a hazard
//   flush         : kills the ID instruction
//   rs1/rs2_data  : forwarded operands (combinational)
//   stall         : hazard stall request (combinational, 0 in reset)
//   busy_vec      : registered scoreboard of pending long-op destinations
//   stall_cnt     : saturating stall-cycle counter, stall_cnt_clr clears
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NSTAGE = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_AW-1:0]        id_rs1,
  input  logic [REG_AW-1:0]        id_rs2,
  input  logic                     id_use_rs1,
  input  logic                     id_use_rs2,
  input  logic [REG_AW-1:0]        id_rd,
  input  logic                     id_lop,
  input  logic [XLEN-1:0]          id_rs1_data,
  input  logic [XLEN-1:0]          id_rs2_data,
  input  logic [NSTAGE-1:0]        fw_valid,
  input  logic [REG_AW*NSTAGE-1:0] fw_rd,
  input  logic [NSTAGE-1:0]        fw_ready,
  input  logic [XLEN*NSTAGE-1:0]   fw_data,
  input  logic                     lop_done,
  input  logic [REG_AW-1:0]        lop_done_rd,
  input  logic [XLEN-1:0]          lop_done_data,
  input  logic                     ext_hold,
  input  logic                     flush,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     stall,
  output logic [NREGS-1:0]         busy_vec,
  output logic [CNT_W-1:0]         stall_cnt,
  input  logic                     stall_cnt_clr
);

  logic          rs1_nr;
  logic          rs2_nr;
  logic          rs1_lop;
  logic          rs2_lop;
  logic          rs1_sb;
  logic          rs2_sb;
  logic          waw_hz;
  logic          issue;
  logic [NREGS-1:0] busy_nxt;
  hazard_cause_e cause;

  forward_operand_sel #(.XLEN(XLEN), .NSTAGE(NSTAGE)) u_sel_rs1 (
    .rs            (id_rs1),
    .fw_valid      (fw_valid),
    .fw_rd         (fw_rd),
    .fw_ready      (fw_ready),
    .fw_data       (fw_data),
    .lop_done      (lop_done),
    .lop_done_rd   (lop_done_rd),
    .lop_done_data (lop_done_data),
    .rf_data       (id_rs1_data),
    .data          (rs1_data),
    .not_ready     (rs1_nr),
    .lop_hit       (rs1_lop)
  );

  forward_operand_sel #(.XLEN(XLEN), .NSTAGE(NSTAGE)) u_sel_rs2 (
    .rs            (id_rs2),
    .fw_valid      (fw_valid),
    .fw_rd         (fw_rd),
    .fw_ready      (fw_ready),
    .fw_data       (fw_data),
    .lop_done      (lop_done),
    .lop_done_rd   (lop_done_rd),
    .lop_done_data (lop_done_data),
    .rf_data       (id_rs2_data),
    .data          (rs2_data),
    .not_ready     (rs2_nr),
    .lop_hit       (rs2_lop)
  );

  // Hazard classification; the completion port resolves a pending register
  // in the same cycle it writes back, for both RAW and WAW.
  always_comb begin
    rs1_sb = busy_vec[id_rs1] && !rs1_lop;
    rs2_sb = busy_vec[id_rs2] && !rs2_lop;
    waw_hz = id_lop && (id_rd != REG_ZERO) && busy_vec[id_rd] &&
             !(lop_done && (lop_done_rd == id_rd));

    cause = HZ_NONE;
    if (id_valid && !flush) begin
      if ((id_use_rs1 && rs1_nr) || (id_use_rs2 && rs2_nr)) begin
        cause = HZ_NOT_READY;
      end else if ((id_use_rs1 && rs1_sb) || (id_use_rs2 && rs2_sb)) begin
        cause = HZ_SCOREBOARD;
      end else if (waw_hz) begin
        cause = HZ_WAW;
      end
    end

    stall = rst_n && (cause != HZ_NONE);
    issue = id_valid && !stall && !ext_hold && !flush;
  end

  // Scoreboard next state: completion clears, issue sets, set wins on a tie.
  always_comb begin
    busy_nxt = busy_vec;
    if (lop_done) begin
      busy_nxt[lop_done_rd] = 1'b0;
    end
    if (issue && id_lop && (id_rd != REG_ZERO)) begin
      busy_nxt[id_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_vec  <= '0;
      stall_cnt <= '0;
    end else begin
      busy_vec <= busy_nxt;
      if (stall_cnt_clr) begin
        stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/forward_hazard_unit.md
Name: forward_hazard_unit

Overview:
Parametrised successor to the two-source forwarding mux. It performs operand bypass for rs1/rs2 from NSTAGE in-flight pipeline stages plus a long-latency (mul/div) completion port, detects load-use and not-ready hazards, and keeps a register scoreboard for multi-cycle ops. It sits between ID/EX operand read and the pipeline control, and drives the stall signal.

Parameters:
XLEN, 32, datapath width
NSTAGE, 2, forwarding source stages; index 0 = youngest (EX/MEM), highest priority
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  instruction present in ID
id_rs1, id_rs2  in  5 each  source register indices
id_use_rs1, id_use_rs2  in  1 each  operand actually read
id_rd  in  5  destination of ID instruction
id_lop  in  1  ID instruction is a long-latency op
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
fw_valid  in  NSTAGE  stage holds a writing instruction
fw_rd  in  5*NSTAGE  stage destination, packed, stage i at [5i+4:5i]
fw_ready  in  NSTAGE  stage result available this cycle (0 = load not yet returned)
fw_data  in  XLEN*NSTAGE  stage result, packed likewise
lop_done  in  1  long op completes this cycle
lop_done_rd  in  5  its destination
lop_done_data  in  XLEN  its result
ext_hold  in  1  downstream hold, blocks issue
flush  in  1  kill ID instruction
rs1_data, rs2_data  out  XLEN each  forwarded operands
stall  out  1  hazard stall request
busy_vec  out  32  scoreboard, bit r = x_r pending long op
stall_cnt  out  CNT_W  saturating count of stall cycles
stall_cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Combinational operand select, per operand, independently: first match in order stage 0..NSTAGE-1, then lop_done, then id_rsX_data. Match = valid & rd==rs & rs!=0. Register 0 always yields the regfile value (expected 0).
- Hit on a stage with fw_ready=0 -> hazard; the operand value is don't-care. Older ready stages must NOT be used beneath a not-ready younger match.
- Scoreboard hazard: operand used & busy_vec[rs]=1 & not matched by lop_done this cycle.
- WAW hazard: id_lop & busy_vec[id_rd] & id_rd!=0, or id_lop while lop_done to the same rd this cycle is allowed (no hazard).
- stall = id_valid & ~flush & (any hazard on a used operand or WAW). Unused operands never cause stall.
- issue = id_valid & ~stall & ~ext_hold & ~flush.
- busy_vec update, next-cycle: clear bit lop_done_rd on lop_done; set bit id_rd on issue & id_lop & id_rd!=0. Set wins on same index same cycle. lop_done on non-busy rd: ignored. Bit 0 is never set. flush does not clear busy bits (issued ops still complete).
- stall_cnt: +1 per cycle with stall=1; saturates at 2^CNT_W-1; stall_cnt_clr takes priority over increment, giving 0 next cycle.
- Reset (rst_n=0 at clk edge): busy_vec=0, stall_cnt=0. While rst_n=0, stall is forced to 0. Reset mid long op drops the pending bit; late lop_done is then ignored.
- Latency: operands/stall are 0-cycle combinational; busy_vec and stall_cnt are 1-cycle registered.

Decomposition:
- Package fwd_pkg: REG_AW=5, NREGS=32, REG_ZERO constant, hazard-cause enum (NONE, NOT_READY, SCOREBOARD, WAW) for debug/assertions.
- Sub-module forward_operand_sel (one operand: priority search, value, not-ready flag), instantiated twice. Scoreboard and counter stay in top.

Test Plan:
- No hazard: rs1=5, rs2=6, fw stage0 rd=5 ready data=0xAA, stage1 rd=6 ready data=0xBB -> rs1_data=0xAA, rs2_data=0xBB, stall=0.
- Priority: stage0 and stage1 both rd=7, data 0x11/0x22, rs1=7 -> 0x11; stage0 fw_ready=0 -> stall=1 (stage1 not used); rs1=0 with stage0 rd=0 -> regfile value.
- Load-use with unused operand: stage0 rd=3 not ready, rs2=3, id_use_rs2=0 -> stall=0.
- Scoreboard: issue long op rd=9; next cycle busy_vec[9]=1; rs1=9 -> stall=1 each cycle; lop_done rd=9 data=0x1234 -> same cycle rs1_data=0x1234, stall=0; following cycle busy_vec[9]=0.
- WAW and simultaneous set/clear: busy[4]=1, id_lop rd=4 -> stall; lop_done rd=4 with issue of a new id_lop rd=4 in the same cycle -> busy_vec[4] stays 1.
- Counter/reset: hold stall for 10 cycles -> stall_cnt=10; CNT_W=4 with 20 stall cycles -> 15; clr and stall together -> 0; rst_n low with busy bits set -> busy_vec=0, stall=0.
